// File: rtl/self_ldst_gen.sv
// Self-test load/store traffic generator. Issues bounded load/store traffic on
// LDQ/STQ channels and checks in-order load returns against per-channel LFSRs.
module self_ldst_gen #(
    parameter int          DATA_WIDTH = 512,
    parameter int          ID_WIDTH   = 7,
    parameter int          NUM_LDQ    = 4,
    parameter int          NUM_STQ    = 1,
    parameter int          MAX_OUT    = 8,
    parameter logic [31:0] SEED       = 32'h3eef
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           mode,
    input  logic [15:0]                    num_req,
    output logic                           init,
    output logic                           done,
    output logic                           err,
    output logic [15:0]                    err_count,
    output logic [NUM_LDQ-1:0]             ldq_addr_valid,
    input  logic [NUM_LDQ-1:0]             ldq_addr_ready,
    output logic [ID_WIDTH*NUM_LDQ-1:0]    ldq_addr,
    input  logic [NUM_LDQ-1:0]             ldq_data_valid,
    output logic [NUM_LDQ-1:0]             ldq_data_ready,
    input  logic [DATA_WIDTH*NUM_LDQ-1:0]  ldq_data,
    output logic [NUM_STQ-1:0]             stq_valid,
    input  logic [NUM_STQ-1:0]             stq_ready,
    output logic [DATA_WIDTH*NUM_STQ-1:0]  stq_data,
    output logic [ID_WIDTH*NUM_STQ-1:0]    stq_id
);
    localparam int            OW        = $clog2(MAX_OUT + 1);
    localparam int            REP       = DATA_WIDTH / 32;
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] seed_of(input int k);
        logic [31:0] s;
        s = SEED + 32'(k);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    state_t                           state_q, state_d;
    logic [15:0]                      num_req_q, num_req_d;
    logic                             err_q, err_d;
    logic [15:0]                      err_count_q, err_count_d;
    logic [16:0]                      err_sum;

    logic [NUM_LDQ-1:0][ID_WIDTH-1:0] ld_id_q, ld_id_d;
    logic [NUM_LDQ-1:0][15:0]         ld_iss_q, ld_iss_d;
    logic [NUM_LDQ-1:0][OW-1:0]       ld_out_q, ld_out_d;
    logic [NUM_LDQ-1:0][31:0]         ld_lfsr_q, ld_lfsr_d;
    logic [NUM_LDQ-1:0]               ld_pend_q, ld_pend_d;
    logic [NUM_LDQ-1:0]               ld_ahs, ld_dhs, ld_ret, ld_err;

    logic [NUM_STQ-1:0][ID_WIDTH-1:0] st_id_q, st_id_d;
    logic [NUM_STQ-1:0][15:0]         st_iss_q, st_iss_d;
    logic [NUM_STQ-1:0][31:0]         st_lfsr_q, st_lfsr_d;
    logic [NUM_STQ-1:0]               st_pend_q, st_pend_d;
    logic [NUM_STQ-1:0]               st_hs;

    logic run, drain, clear, unlimited, all_issued, all_idle;

    assign init      = (state_q == S_INIT);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign err_count = err_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_INIT;
            S_INIT:  state_d = S_RUN;
            S_RUN:   if (!enable || all_issued) state_d = S_DRAIN;
            S_DRAIN: if (all_idle) state_d = S_DONE;
            S_DONE:  if (!enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Valids are built only from registered state plus a pending flag, so a
    // request accepted for issue stays up across RUN->DRAIN until ready.
    always_comb begin
        run            = (state_q == S_RUN);
        drain          = (state_q == S_DRAIN);
        clear          = (state_q == S_INIT);
        unlimited      = (num_req_q == 16'h0);
        all_issued     = !unlimited;
        all_idle       = 1'b1;
        ldq_addr_valid = '0;
        ldq_addr       = '0;
        ldq_data_ready = {NUM_LDQ{run || drain}};
        stq_valid      = '0;
        stq_data       = '0;
        stq_id         = '0;
        ld_ahs         = '0;
        ld_dhs         = '0;
        ld_ret         = '0;
        ld_err         = '0;
        st_hs          = '0;
        ld_id_d        = ld_id_q;
        ld_iss_d       = ld_iss_q;
        ld_out_d       = ld_out_q;
        ld_lfsr_d      = ld_lfsr_q;
        ld_pend_d      = '0;
        st_id_d        = st_id_q;
        st_iss_d       = st_iss_q;
        st_lfsr_d      = st_lfsr_q;
        st_pend_d      = '0;

        for (int i = 0; i < NUM_LDQ; i++) begin
            ldq_addr_valid[i] = (run && (unlimited || ld_iss_q[i] < num_req_q)
                                 && ld_out_q[i] < MAX_OUT_C) || ld_pend_q[i];
            ldq_addr[i*ID_WIDTH +: ID_WIDTH] = ld_id_q[i];
            ld_ahs[i]    = ldq_addr_valid[i] && ldq_addr_ready[i];
            ld_dhs[i]    = ldq_data_valid[i] && ldq_data_ready[i];
            ld_ret[i]    = ld_dhs[i] && (ld_out_q[i] != '0);
            ld_err[i]    = (ld_dhs[i] && (ld_out_q[i] == '0))
                        || (ld_ret[i] && mode
                            && ldq_data[i*DATA_WIDTH +: DATA_WIDTH] != {REP{ld_lfsr_q[i]}});
            ld_pend_d[i] = ldq_addr_valid[i] && !ldq_addr_ready[i];
            if (ld_ahs[i]) begin
                ld_id_d[i]  = ld_id_q[i] + 1'b1;
                ld_iss_d[i] = ld_iss_q[i] + 1'b1;
            end
            if (ld_ahs[i] && !ld_ret[i])
                ld_out_d[i] = ld_out_q[i] + 1'b1;
            else if (!ld_ahs[i] && ld_ret[i])
                ld_out_d[i] = ld_out_q[i] - 1'b1;
            if (ld_ret[i])
                ld_lfsr_d[i] = lfsr_next(ld_lfsr_q[i]);
            if (clear) begin
                ld_id_d[i]   = '0;
                ld_iss_d[i]  = '0;
                ld_out_d[i]  = '0;
                ld_lfsr_d[i] = seed_of(i);
                ld_pend_d[i] = 1'b0;
            end
            if (ld_iss_q[i] != num_req_q) all_issued = 1'b0;
            if (ld_out_q[i] != '0 || ld_pend_q[i]) all_idle = 1'b0;
        end

        for (int j = 0; j < NUM_STQ; j++) begin
            stq_valid[j] = (run && (unlimited || st_iss_q[j] < num_req_q)) || st_pend_q[j];
            stq_data[j*DATA_WIDTH +: DATA_WIDTH] = stq_valid[j] ? {REP{st_lfsr_q[j]}} : '0;
            stq_id[j*ID_WIDTH +: ID_WIDTH] = st_id_q[j];
            st_hs[j]     = stq_valid[j] && stq_ready[j];
            st_pend_d[j] = stq_valid[j] && !stq_ready[j];
            if (st_hs[j]) begin
                st_lfsr_d[j] = lfsr_next(st_lfsr_q[j]);
                st_id_d[j]   = st_id_q[j] + 1'b1;
                st_iss_d[j]  = st_iss_q[j] + 1'b1;
            end
            if (clear) begin
                st_id_d[j]   = '0;
                st_iss_d[j]  = '0;
                st_lfsr_d[j] = seed_of(NUM_LDQ + j);
                st_pend_d[j] = 1'b0;
            end
            if (st_iss_q[j] != num_req_q) all_issued = 1'b0;
            if (st_pend_q[j]) all_idle = 1'b0;
        end

        err_sum = {1'b0, err_count_q};
        for (int i = 0; i < NUM_LDQ; i++)
            err_sum = err_sum + 17'(ld_err[i]);
        err_count_d = clear ? 16'h0 : (err_sum[16] ? 16'hFFFF : err_sum[15:0]);
        err_d       = clear ? 1'b0 : (err_q || (|ld_err));
        num_req_d   = clear ? num_req : num_req_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_req_q   <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            ld_id_q     <= '0;
            ld_iss_q    <= '0;
            ld_out_q    <= '0;
            ld_pend_q   <= '0;
            st_id_q     <= '0;
            st_iss_q    <= '0;
            st_pend_q   <= '0;
            for (int i = 0; i < NUM_LDQ; i++) ld_lfsr_q[i] <= seed_of(i);
            for (int j = 0; j < NUM_STQ; j++) st_lfsr_q[j] <= seed_of(NUM_LDQ + j);
        end else begin
            state_q     <= state_d;
            num_req_q   <= num_req_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            ld_id_q     <= ld_id_d;
            ld_iss_q    <= ld_iss_d;
            ld_out_q    <= ld_out_d;
            ld_lfsr_q   <= ld_lfsr_d;
            ld_pend_q   <= ld_pend_d;
            st_id_q     <= st_id_d;
            st_iss_q    <= st_iss_d;
            st_lfsr_q   <= st_lfsr_d;
            st_pend_q   <= st_pend_d;
        end
    end
endmodule

// File: tb/tb_self_ldst_gen.sv
// Bench for self_ldst_gen: one load and one store channel, MAX_OUT=2, with a
// scoreboarded memory model echoing the load LFSR pattern.
module tb_self_ldst_gen;
    localparam int          DW   = 64;
    localparam int          IDW  = 7;
    localparam logic [31:0] SEED = 32'h3eef;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            mode = 1'b0;
    logic [15:0]     num_req = 16'h0;
    logic            init, done, err;
    logic [15:0]     err_count;
    logic [0:0]      ldq_addr_valid, ldq_addr_ready, ldq_data_valid, ldq_data_ready;
    logic [IDW-1:0]  ldq_addr, stq_id;
    logic [DW-1:0]   ldq_data, stq_data;
    logic [0:0]      stq_valid, stq_ready;

    always #5 clk = ~clk;

    self_ldst_gen #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .NUM_LDQ(1), .NUM_STQ(1),
                    .MAX_OUT(2), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .num_req(num_req),
        .init(init), .done(done), .err(err), .err_count(err_count),
        .ldq_addr_valid(ldq_addr_valid), .ldq_addr_ready(ldq_addr_ready),
        .ldq_addr(ldq_addr), .ldq_data_valid(ldq_data_valid),
        .ldq_data_ready(ldq_data_ready), .ldq_data(ldq_data),
        .stq_valid(stq_valid), .stq_ready(stq_ready), .stq_data(stq_data),
        .stq_id(stq_id)
    );

    int checks = 0;
    int failures = 0;

    bit          ar_rdy = 0, st_rdy = 0, mem_auto = 0, force_beat = 0, beat_from_q = 0;
    int          mem_credit = 0, corrupt_idx = -1, ret_idx = 0;
    int          n_ld_hs = 0, n_st_hs = 0, n_ret = 0;
    logic [63:0] mem_q[$];
    logic [31:0] m_ld_lfsr, m_st_lfsr;
    logic [6:0]  m_ld_id, m_st_id;
    logic [63:0] first_st;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Drive inputs at the falling edge, then record the handshakes that the
    // next rising edge will complete.
    task automatic cycle();
        @(negedge clk);
        ldq_addr_ready = ar_rdy;
        stq_ready      = st_rdy;
        beat_from_q    = 0;
        if (force_beat) begin
            ldq_data_valid = 1'b1;
            ldq_data       = 64'hdead_beef_0bad_f00d;
        end else if (mem_q.size() > 0 && (mem_auto || mem_credit > 0)) begin
            ldq_data_valid = 1'b1;
            ldq_data       = (ret_idx == corrupt_idx) ? (mem_q[0] ^ 64'h1) : mem_q[0];
            beat_from_q    = 1;
        end else begin
            ldq_data_valid = 1'b0;
            ldq_data       = '0;
        end
        #1;
        if (ldq_addr_valid[0] && ldq_addr_ready[0]) begin
            checks++;
            if (ldq_addr !== m_ld_id) begin
                failures++;
                $display("FAIL ld_id got=%0d exp=%0d", ldq_addr, m_ld_id);
            end
            m_ld_id++;
            mem_q.push_back({m_ld_lfsr, m_ld_lfsr});
            m_ld_lfsr = lfsr_step(m_ld_lfsr);
            n_ld_hs++;
        end
        if (ldq_data_valid[0] && ldq_data_ready[0]) begin
            if (beat_from_q) begin
                void'(mem_q.pop_front());
                ret_idx++;
                if (!mem_auto) mem_credit--;
            end
            n_ret++;
        end
        if (stq_valid[0] && stq_ready[0]) begin
            if (n_st_hs == 0) first_st = stq_data;
            checks++;
            if (stq_data !== {m_st_lfsr, m_st_lfsr} || stq_id !== m_st_id) begin
                failures++;
                $display("FAIL st_beat got=%h/%0d exp=%h/%0d", stq_data, stq_id,
                         {m_st_lfsr, m_st_lfsr}, m_st_id);
            end
            m_st_lfsr = lfsr_step(m_st_lfsr);
            m_st_id++;
            n_st_hs++;
        end
    endtask

    task automatic start_run(input logic [15:0] nr, input logic md);
        num_req = nr;
        mode = md;
        m_ld_lfsr = SEED;
        m_st_lfsr = SEED + 32'd1;
        m_ld_id = 0;
        m_st_id = 0;
        mem_q.delete();
        n_ld_hs = 0; n_st_hs = 0; n_ret = 0; ret_idx = 0;
        corrupt_idx = -1; mem_credit = 0;
        enable = 1'b1;
        cycle();
        checks++;
        if (init !== 1'b1) begin failures++; $display("FAIL init_pulse got=%b exp=1", init); end
        cycle();
        checks++;
        if (init !== 1'b0) begin failures++; $display("FAIL init_one_cycle got=%b exp=0", init); end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            cycle();
            k++;
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL done_timeout got=%b exp=1", done); end
    endtask

    task automatic end_run();
        enable = 1'b0;
        cycle();
        cycle();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_clear got=%b exp=0", done); end
    endtask

    task automatic test_reset();
        cycle();
        cycle();
        checks++;
        if ({init, done, err, err_count, ldq_addr_valid, ldq_addr, ldq_data_ready,
             stq_valid, stq_data, stq_id} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got nonzero exp=0");
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        ar_rdy = 1; st_rdy = 1; mem_auto = 1;
        start_run(16'd3, 1'b1);
        checks++;
        if (ldq_addr_valid !== 1'b1 || stq_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_run_valid got=%b/%b exp=1/1", ldq_addr_valid, stq_valid);
        end
        wait_done(100);
        checks++;
        if (n_ld_hs != 3 || n_st_hs != 3) begin
            failures++;
            $display("FAIL basic_counts got=%0d/%0d exp=3/3", n_ld_hs, n_st_hs);
        end
        checks++;
        if (first_st !== 64'h00003ef0_00003ef0) begin
            failures++;
            $display("FAIL first_store got=%h exp=00003ef000003ef0", first_st);
        end
        checks++;
        if (err !== 1'b0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL basic_err got=%b/%0d exp=0/0", err, err_count);
        end
        repeat (3) cycle();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL done_held got=%b exp=1", done); end
        end_run();
    endtask

    task automatic test_backpressure();
        ar_rdy = 0; st_rdy = 0; mem_auto = 1;
        start_run(16'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ldq_addr_valid !== 1'b1 || ldq_addr !== 7'd0 || stq_valid !== 1'b1
                || stq_data !== 64'h00003ef0_00003ef0 || stq_id !== 7'd0) begin
                failures++;
                $display("FAIL bp_stable cyc=%0d got=%b/%0d/%b/%h", i, ldq_addr_valid,
                         ldq_addr, stq_valid, stq_data);
            end
            cycle();
        end
        ar_rdy = 1; st_rdy = 1;
        wait_done(100);
        checks++;
        if (n_ld_hs != 2 || n_st_hs != 2) begin
            failures++;
            $display("FAIL bp_resume got=%0d/%0d exp=2/2", n_ld_hs, n_st_hs);
        end
        end_run();
    endtask

    task automatic test_outstanding();
        ar_rdy = 1; st_rdy = 1; mem_auto = 0;
        start_run(16'd5, 1'b1);
        repeat (7) cycle();
        checks++;
        if (n_ld_hs != 2 || ldq_addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL out_limit got=%0d/%b exp=2/0", n_ld_hs, ldq_addr_valid);
        end
        mem_credit = 1;
        repeat (6) cycle();
        checks++;
        if (n_ld_hs != 3 || n_ret != 1 || ldq_addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL out_one_more got=%0d/%0d/%b exp=3/1/0", n_ld_hs, n_ret, ldq_addr_valid);
        end
        mem_auto = 1;
        wait_done(200);
        checks++;
        if (n_ld_hs != 5 || err !== 1'b0) begin
            failures++;
            $display("FAIL out_finish got=%0d/%b exp=5/0", n_ld_hs, err);
        end
        end_run();
    endtask

    task automatic test_data_check();
        ar_rdy = 1; st_rdy = 1; mem_auto = 1;
        start_run(16'd4, 1'b1);
        corrupt_idx = 1;
        wait_done(200);
        checks++;
        if (err !== 1'b1 || err_count !== 16'd1) begin
            failures++;
            $display("FAIL corrupt_mode1 got=%b/%0d exp=1/1", err, err_count);
        end
        end_run();
        start_run(16'd4, 1'b0);
        corrupt_idx = 1;
        wait_done(200);
        checks++;
        if (err !== 1'b0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL corrupt_mode0 got=%b/%0d exp=0/0", err, err_count);
        end
        end_run();
    endtask

    task automatic test_unexpected();
        ar_rdy = 0; st_rdy = 1; mem_auto = 0;
        start_run(16'd3, 1'b0);
        force_beat = 1;
        cycle();
        force_beat = 0;
        cycle();
        checks++;
        if (err !== 1'b1 || err_count !== 16'd1) begin
            failures++;
            $display("FAIL unexp_err got=%b/%0d exp=1/1", err, err_count);
        end
        ar_rdy = 1;
        repeat (6) cycle();
        checks++;
        if (n_ld_hs != 2) begin
            failures++;
            $display("FAIL unexp_outstanding got=%0d exp=2", n_ld_hs);
        end
        mem_auto = 1;
        wait_done(200);
        checks++;
        if (err_count !== 16'd1) begin
            failures++;
            $display("FAIL unexp_final got=%0d exp=1", err_count);
        end
        end_run();
    endtask

    task automatic test_continuous();
        ar_rdy = 1; st_rdy = 1; mem_auto = 1;
        start_run(16'd0, 1'b1);
        repeat (400) cycle();
        enable = 1'b0;
        wait_done(100);
        checks++;
        if (n_ld_hs <= 128 || n_st_hs <= 128 || mem_q.size() != 0 || err !== 1'b0) begin
            failures++;
            $display("FAIL cont_run got=%0d/%0d/%0d/%b", n_ld_hs, n_st_hs, mem_q.size(), err);
        end
        cycle();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL cont_idle got=%b exp=0", done); end
    endtask

    task automatic test_reset_mid_run();
        ar_rdy = 1; st_rdy = 1; mem_auto = 1;
        start_run(16'd0, 1'b1);
        repeat (5) cycle();
        rst = 1'b1;
        #1;
        checks++;
        if ({init, done, err, err_count, ldq_addr_valid, ldq_addr, ldq_data_ready,
             stq_valid, stq_data, stq_id} !== '0) begin
            failures++;
            $display("FAIL midrun_reset got=%b/%b/%h exp=0", ldq_addr_valid, stq_valid, stq_data);
        end
        enable = 1'b0;
        mem_auto = 0;
        mem_q.delete();
        cycle();
        rst = 1'b0;
        cycle();
        start_run(16'd2, 1'b1);
        mem_auto = 1;
        wait_done(100);
        checks++;
        if (n_ld_hs != 2 || err !== 1'b0) begin
            failures++;
            $display("FAIL after_reset got=%0d/%b exp=2/0", n_ld_hs, err);
        end
        end_run();
    endtask

    initial begin
        ldq_addr_ready = '0;
        ldq_data_valid = '0;
        ldq_data       = '0;
        stq_ready      = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_outstanding();
        test_data_check();
        test_unexpected();
        test_continuous();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
